memory_access_stage: RTL and testbench

// - RV32 MEM stage: sits between execute and write_back_stage; consumes ALU result + store data.
// - Drives a valid/ready data-memory port, formats load data, emits a one-cycle write-back beat.
// - Blocking: one instruction in flight; stalls execute via in_ready while a memory access is pending.

---
 rtl/memory_access_stage.sv | 176 +++++++++++++++++
 tb/tb_memory_access_stage.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/memory_access_stage.sv
// RV32 memory-access stage: one blocking access in flight, byte-lane store formatting and load extraction.
// Optional misaligned-access trap is compiled in with `define MEM_MISALIGN_TRAP_EN.
module memory_access_stage #(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_alu_result,
  input  logic [XLEN-1:0]   in_rs2_data,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_reg_we,
  input  logic              in_is_load,
  input  logic              in_is_store,
  input  logic [2:0]        in_funct3,
  output logic              dmem_req_valid,
  input  logic              dmem_req_ready,
  output logic              dmem_we,
  output logic [XLEN-1:0]   dmem_addr,
  output logic [XLEN-1:0]   dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_rsp_valid,
  input  logic [XLEN-1:0]   dmem_rdata,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              wb_trap
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

  state_t state, state_next;

  logic [XLEN-1:0]   addr_p0;
  logic [XLEN-1:0]   wdata_p0;
  logic [REG_AW-1:0] rd_p0;
  logic              reg_we_p0;
  logic              is_load_p0;
  logic [2:0]        funct3_p0;

  logic              vld_p1;
  logic              we_p1;
  logic              trap_p1;
  logic [REG_AW-1:0] rd_p1;
  logic [XLEN-1:0]   data_p1;

  logic accept;
  logic is_mem;
  logic misalign;

  // Access size comes from funct3[1:0] (00 byte, 01 half, else word); funct3[2] selects zero-extension.
  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   store_be = 4'b0001 << off;
      2'b01:   store_be = 4'b0011 << {off[1], 1'b0};
      default: store_be = 4'b1111;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   store_wdata = {4{d[7:0]}};
      2'b01:   store_wdata = {2{d[15:0]}};
      default: store_wdata = d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_format(input logic [2:0] f3, input logic [1:0] off,
                                                  input logic [XLEN-1:0] word);
    logic [XLEN-1:0] byte_sh;
    logic [XLEN-1:0] half_sh;
    logic [7:0]      b;
    logic [15:0]     h;
    byte_sh = word >> {off, 3'b000};
    half_sh = word >> {off[1], 4'b0000};
    b = byte_sh[7:0];
    h = half_sh[15:0];
    case (f3[1:0])
      2'b00:   load_format = f3[2] ? {{(XLEN-8){1'b0}}, b}  : {{(XLEN-8){b[7]}}, b};
      2'b01:   load_format = f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: load_format = word;
    endcase
  endfunction

`ifdef MEM_MISALIGN_TRAP_EN
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3[1:0])
      2'b00:   is_misaligned = 1'b0;
      2'b01:   is_misaligned = off[0];
      default: is_misaligned = (off != 2'b00);
    endcase
  endfunction

  assign misalign = is_mem && is_misaligned(in_funct3, in_alu_result[1:0]);
`else
  assign misalign = 1'b0;
`endif

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_mem   = in_is_load || in_is_store;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept && is_mem && !misalign) state_next = REQ;
      REQ:     if (dmem_req_ready) state_next = is_load_p0 ? WAIT : IDLE;
      WAIT:    if (dmem_rsp_valid) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Stage p0: instruction captured at acceptance, held for the whole access
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p0    <= in_alu_result;
      wdata_p0   <= in_rs2_data;
      rd_p0      <= in_rd;
      reg_we_p0  <= in_reg_we;
      is_load_p0 <= in_is_load;
      funct3_p0  <= in_funct3;
    end
  end

  // Request outputs are forced to zero outside REQ so unloaded capture registers never leak out.
  assign dmem_req_valid = (state == REQ);
  assign dmem_we        = dmem_req_valid && !is_load_p0;
  assign dmem_addr      = dmem_req_valid ? {addr_p0[XLEN-1:2], 2'b00} : '0;
  assign dmem_wdata     = dmem_req_valid ? store_wdata(funct3_p0, wdata_p0) : '0;
  assign dmem_be        = dmem_req_valid ? store_be(funct3_p0, addr_p0[1:0]) : 4'b0000;

  // Stage p1: one-cycle write-back beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      trap_p1 <= 1'b0;
      rd_p1   <= '0;
      data_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      we_p1   <= 1'b0;
      trap_p1 <= 1'b0;
      if (accept && (!is_mem || misalign)) begin
        vld_p1  <= 1'b1;
        trap_p1 <= misalign;
        we_p1   <= !misalign && in_reg_we && (in_rd != '0);
        rd_p1   <= in_rd;
        data_p1 <= in_alu_result;
      end else if (state == REQ && dmem_req_ready && !is_load_p0) begin
        vld_p1  <= 1'b1;
        rd_p1   <= rd_p0;
      end else if (state == WAIT && dmem_rsp_valid) begin
        vld_p1  <= 1'b1;
        we_p1   <= reg_we_p0 && (rd_p0 != '0);
        rd_p1   <= rd_p0;
        data_p1 <= load_format(funct3_p0, addr_p0[1:0], dmem_rdata);
      end
    end
  end

  assign wb_valid = vld_p1;
  assign wb_we    = we_p1;
  assign wb_rd    = rd_p1;
  assign wb_data  = data_p1;
  assign wb_trap  = trap_p1;

endmodule

// File: tb/tb_memory_access_stage.sv
// Directed bench for memory_access_stage; inputs driven and outputs sampled on the falling edge.
module tb_memory_access_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_rs2_data;
  logic [4:0]  in_rd;
  logic        in_reg_we;
  logic        in_is_load;
  logic        in_is_store;
  logic [2:0]  in_funct3;
  logic        dmem_req_valid;
  logic        dmem_req_ready;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_rsp_valid;
  logic [31:0] dmem_rdata;
  logic        wb_valid;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_trap;

  int checks = 0;
  int errors = 0;

  memory_access_stage #(.XLEN(32), .REG_AW(5)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_result(in_alu_result), .in_rs2_data(in_rs2_data),
    .in_rd(in_rd), .in_reg_we(in_reg_we),
    .in_is_load(in_is_load), .in_is_store(in_is_store), .in_funct3(in_funct3),
    .dmem_req_valid(dmem_req_valid), .dmem_req_ready(dmem_req_ready),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .wb_trap(wb_trap)
  );

  always #5 clk = ~clk;

  // Presents one instruction for a single cycle; returns at the falling edge after acceptance.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic [4:0] rd, input logic we);
    in_valid = 1'b1; in_is_load = ld; in_is_store = st; in_funct3 = f3;
    in_alu_result = alu; in_rs2_data = rs2; in_rd = rd; in_reg_we = we;
    @(negedge clk);
    in_valid = 1'b0; in_is_load = 1'b0; in_is_store = 1'b0;
  endtask

  // Load with immediate request handshake and response; returns in the write-back cycle.
  task automatic do_load(input logic [2:0] f3, input logic [31:0] addr, input logic [4:0] rd,
                         input logic [31:0] rdata);
    issue(1'b1, 1'b0, f3, addr, 32'h0, rd, 1'b1);
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = rdata;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid = 0; in_alu_result = 0; in_rs2_data = 0; in_rd = 0; in_reg_we = 0;
    in_is_load = 0; in_is_store = 0; in_funct3 = 0;
    dmem_req_ready = 0; dmem_rsp_valid = 0; dmem_rdata = 0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid got %b exp 0", wb_valid); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid got %b exp 0", dmem_req_valid); end
    checks++; if (wb_data !== 32'h0) begin errors++; $display("FAIL reset_wb_data got %h exp 0", wb_data); end
    checks++; if (dmem_be !== 4'h0) begin errors++; $display("FAIL reset_be got %b exp 0000", dmem_be); end
    checks++; if (wb_trap !== 1'b0) begin errors++; $display("FAIL reset_trap got %b exp 0", wb_trap); end
  endtask

  task automatic test_alu();
    issue(1'b0, 1'b0, 3'b000, 32'h0000_1234, 32'h0, 5'd5, 1'b1);
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL alu_wb_valid got %b exp 1", wb_valid); end
    checks++; if (wb_we !== 1'b1) begin errors++; $display("FAIL alu_wb_we got %b exp 1", wb_we); end
    checks++; if (wb_rd !== 5'd5) begin errors++; $display("FAIL alu_wb_rd got %0d exp 5", wb_rd); end
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL alu_wb_data got %h exp 00001234", wb_data); end
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL alu_req_valid got %b exp 0", dmem_req_valid); end
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL alu_wb_drop got %b exp 0", wb_valid); end
  endtask

  task automatic test_lb_stall();
    issue(1'b1, 1'b0, 3'b000, 32'h0000_0103, 32'h0, 5'd7, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checks++; if (dmem_req_valid !== 1'b1) begin errors++; $display("FAIL lb_req_valid[%0d] got %b exp 1", i, dmem_req_valid); end
      checks++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL lb_addr[%0d] got %h exp 00000100", i, dmem_addr); end
      checks++; if (dmem_we !== 1'b0) begin errors++; $display("FAIL lb_we[%0d] got %b exp 0", i, dmem_we); end
      checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lb_in_ready[%0d] got %b exp 0", i, in_ready); end
      @(negedge clk);
    end
    dmem_req_ready = 1'b1;
    @(negedge clk);
    dmem_req_ready = 1'b0;
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_req got %b exp 0", dmem_req_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL lb_wait_ready got %b exp 0", in_ready); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL lb_wait_wb got %b exp 0", wb_valid); end
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h80FF_FFFF;
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lb_wb_valid got %b exp 1", wb_valid); end
    checks++; if (wb_data !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_wb_data got %h exp ffffff80", wb_data); end
    checks++; if (wb_we !== 1'b1 || wb_rd !== 5'd7) begin errors++; $display("FAIL lb_wb_we_rd got %b/%0d exp 1/7", wb_we, wb_rd); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL lb_done_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_load_lanes();
    do_load(3'b101, 32'h0000_0102, 5'd3, 32'hBEEF_1234);
    checks++; if (wb_data !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_data got %h exp 0000beef", wb_data); end
    do_load(3'b001, 32'h0000_0102, 5'd3, 32'hBEEF_1234);
    checks++; if (wb_data !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_data got %h exp ffffbeef", wb_data); end
    do_load(3'b001, 32'h0000_0100, 5'd3, 32'hBEEF_1234);
    checks++; if (wb_data !== 32'h0000_1234) begin errors++; $display("FAIL lh_low_data got %h exp 00001234", wb_data); end
    do_load(3'b100, 32'h0000_0101, 5'd3, 32'h1234_5678);
    checks++; if (wb_data !== 32'h0000_0056) begin errors++; $display("FAIL lbu_data got %h exp 00000056", wb_data); end
    do_load(3'b100, 32'h0000_0103, 5'd3, 32'h80FF_FFFF);
    checks++; if (wb_data !== 32'h0000_0080) begin errors++; $display("FAIL lbu_hi_data got %h exp 00000080", wb_data); end
    do_load(3'b110, 32'h0000_0104, 5'd3, 32'hCAFE_F00D);
    checks++; if (wb_data !== 32'hCAFE_F00D) begin errors++; $display("FAIL f3_110_data got %h exp cafef00d", wb_data); end
  endtask

  task automatic test_stores();
    issue(1'b0, 1'b1, 3'b000, 32'h0000_0101, 32'h1234_56AB, 5'd9, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (dmem_req_valid !== 1'b1 || dmem_we !== 1'b1) begin errors++; $display("FAIL sb_req[%0d] got %b/%b exp 1/1", i, dmem_req_valid, dmem_we); end
      checks++; if (dmem_be !== 4'b0010) begin errors++; $display("FAIL sb_be[%0d] got %b exp 0010", i, dmem_be); end
      checks++; if (dmem_wdata !== 32'hABAB_ABAB) begin errors++; $display("FAIL sb_wdata[%0d] got %h exp abababab", i, dmem_wdata); end
      checks++; if (dmem_addr !== 32'h0000_0100) begin errors++; $display("FAIL sb_addr[%0d] got %h exp 00000100", i, dmem_addr); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sb_early_wb[%0d] got %b exp 0", i, wb_valid); end
      if (i == 1) dmem_req_ready = 1'b1;
      @(negedge clk);
    end
    dmem_req_ready = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL sb_retire got %b/%b exp 1/0", wb_valid, wb_we); end
    checks++; if (in_ready !== 1'b1 || dmem_req_valid !== 1'b0) begin errors++; $display("FAIL sb_idle got %b/%b exp 1/0", in_ready, dmem_req_valid); end
    issue(1'b0, 1'b1, 3'b001, 32'h0000_0102, 32'h0000_CAFE, 5'd0, 1'b0);
    checks++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'hCAFE_CAFE) begin errors++; $display("FAIL sh_be_wdata got %b/%h exp 1100/cafecafe", dmem_be, dmem_wdata); end
    dmem_req_ready = 1'b1; @(negedge clk); dmem_req_ready = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h0000_0104, 32'h1122_3344, 5'd0, 1'b0);
    checks++; if (dmem_be !== 4'b1111 || dmem_wdata !== 32'h1122_3344 || dmem_addr !== 32'h0000_0104) begin
      errors++; $display("FAIL sw_req got %b/%h/%h exp 1111/11223344/00000104", dmem_be, dmem_wdata, dmem_addr); end
    dmem_req_ready = 1'b1; @(negedge clk); dmem_req_ready = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL sw_retire got %b/%b exp 1/0", wb_valid, wb_we); end
  endtask

  task automatic test_rd0_and_reset_wait();
    do_load(3'b010, 32'h0000_0200, 5'd0, 32'hDEAD_BEEF);
    checks++; if (wb_valid !== 1'b1 || wb_we !== 1'b0) begin errors++; $display("FAIL lw_rd0 got %b/%b exp 1/0", wb_valid, wb_we); end
    checks++; if (wb_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL lw_rd0_data got %h exp deadbeef", wb_data); end
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0, 5'd4, 1'b1);
    dmem_req_ready = 1'b1; @(negedge clk); dmem_req_ready = 1'b0;
    rst = 1'b1; @(negedge clk); rst = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h5555_AAAA;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_ready got %b exp 1", in_ready); end
    @(negedge clk);
    dmem_rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rstwait_stray_wb got %b exp 0", wb_valid); end
    checks++; if (dmem_req_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL rstwait_idle got %b/%b exp 0/1", dmem_req_valid, in_ready); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [4:0]  rds  [3];
    vals[0] = 32'h0000_0011; vals[1] = 32'hFFFF_0022; vals[2] = 32'h0000_0033;
    rds[0] = 5'd1; rds[1] = 5'd0; rds[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_is_load = 1'b0; in_is_store = 1'b0; in_funct3 = 3'b000;
      in_alu_result = vals[i]; in_rd = rds[i]; in_reg_we = 1'b1;
      @(negedge clk);
      checks++; if (wb_valid !== 1'b1 || wb_data !== vals[i]) begin errors++; $display("FAIL b2b_beat[%0d] got %b/%h exp 1/%h", i, wb_valid, wb_data, vals[i]); end
      checks++; if (wb_we !== (rds[i] != 5'd0)) begin errors++; $display("FAIL b2b_we[%0d] got %b exp %b", i, wb_we, rds[i] != 5'd0); end
    end
    in_valid = 1'b0;
    @(negedge clk);
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL b2b_tail got %b exp 0", wb_valid); end
  endtask

  task automatic test_misalign();
    issue(1'b1, 1'b0, 3'b010, 32'h0000_0102, 32'h0, 5'd6, 1'b1);
`ifdef MEM_MISALIGN_TRAP_EN
    checks++; if (dmem_req_valid !== 1'b0) begin errors++; $display("FAIL trap_req got %b exp 0", dmem_req_valid); end
    checks++; if (wb_valid !== 1'b1 || wb_trap !== 1'b1 || wb_we !== 1'b0) begin
      errors++; $display("FAIL trap_beat got v%b t%b w%b exp v1 t1 w0", wb_valid, wb_trap, wb_we); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL trap_ready got %b exp 1", in_ready); end
    @(negedge clk);
    checks++; if (wb_trap !== 1'b0) begin errors++; $display("FAIL trap_drop got %b exp 0", wb_trap); end
`else
    checks++; if (dmem_req_valid !== 1'b1 || dmem_addr !== 32'h0000_0100) begin
      errors++; $display("FAIL noTrap_req got %b/%h exp 1/00000100", dmem_req_valid, dmem_addr); end
    checks++; if (wb_valid !== 1'b0 || wb_trap !== 1'b0) begin errors++; $display("FAIL noTrap_beat got %b/%b exp 0/0", wb_valid, wb_trap); end
    dmem_req_ready = 1'b1; @(negedge clk); dmem_req_ready = 1'b0;
    dmem_rsp_valid = 1'b1; dmem_rdata = 32'h0BAD_F00D; @(negedge clk); dmem_rsp_valid = 1'b0;
    checks++; if (wb_valid !== 1'b1 || wb_data !== 32'h0BAD_F00D || wb_trap !== 1'b0) begin
      errors++; $display("FAIL noTrap_load got %b/%h/%b exp 1/0badf00d/0", wb_valid, wb_data, wb_trap); end
`endif
  endtask

  initial begin
    test_reset();
    test_alu();
    test_lb_stall();
    test_load_lanes();
    test_stores();
    test_rd0_and_reset_wait();
    test_back_to_back();
    test_misalign();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
